// File: rtl/sprite_drawer.sv
// sprite_drawer: draws one SPR_W x SPR_H sprite from a synchronous ROM into
// the VGA adapter, one pixel per clock, in raster order. Pixels whose ROM
// value equals TRANSPARENT are skipped, and off-screen pixels are clipped.
// In erase mode bg_color is painted over the sprite's opaque footprint.
//
// Ports:
//   clock, resetn          clock, asynchronous active-low reset
//   start                  begin a draw (sampled only while idle)
//   erase, x0, y0,         draw context, latched with start
//   bg_color
//   rom_addr / rom_data    sprite ROM port (rom_data lags rom_addr by 1 cycle)
//   x, y, color, write     registered pixel stream to vga_adapter
//   busy                   draw in progress
//   done                   one-cycle pulse when a draw completes
module sprite_drawer #(
  parameter int nX          = 10,
  parameter int nY          = 9,
  parameter int COLOR_DEPTH = 9,
  parameter int SPR_W       = 16,
  parameter int SPR_H       = 16,
  parameter int AW          = 8,
  parameter int X_MAX       = 640,
  parameter int Y_MAX       = 480,
  parameter int TRANSPARENT = 0
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   erase,
  input  logic [nX-1:0]          x0,
  input  logic [nY-1:0]          y0,
  input  logic [COLOR_DEPTH-1:0] bg_color,
  output logic [AW-1:0]          rom_addr,
  input  logic [COLOR_DEPTH-1:0] rom_data,
  output logic [nX-1:0]          x,
  output logic [nY-1:0]          y,
  output logic [COLOR_DEPTH-1:0] color,
  output logic                   write,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t state_q, state_d;

  // Coordinate sums carry one extra bit so a sprite hanging past the right
  // or bottom edge is clipped instead of wrapping onto column/row 0.
  function automatic logic [nX:0] add_x(input logic [nX-1:0] base,
                                        input logic [CW-1:0] off);
    return {1'b0, base} + (nX+1)'(off);
  endfunction

  function automatic logic [nY:0] add_y(input logic [nY-1:0] base,
                                        input logic [RW-1:0] off);
    return {1'b0, base} + (nY+1)'(off);
  endfunction

  function automatic logic on_screen(input logic [nX:0] sx,
                                     input logic [nY:0] sy);
    return (sx < (nX+1)'(X_MAX)) && (sy < (nY+1)'(Y_MAX));
  endfunction

  logic [CW-1:0]          col_p0;
  logic [RW-1:0]          row_p0;
  logic [AW-1:0]          addr_p0;
  logic                   vld_p0;
  logic                   last_p0;
  logic                   accept;
  logic                   fin_q;
  logic                   busy_q;
  logic                   done_q;

  logic [nX-1:0]          x0_q;
  logic [nY-1:0]          y0_q;
  logic                   erase_q;
  logic [COLOR_DEPTH-1:0] bg_q;

  logic [CW-1:0]          col_p1;
  logic [RW-1:0]          row_p1;
  logic                   vld_p1;
  logic [nX:0]            sum_x_p1;
  logic [nY:0]            sum_y_p1;
  logic                   opaque_p1;

  logic [nX-1:0]          x_p2;
  logic [nY-1:0]          y_p2;
  logic [COLOR_DEPTH-1:0] color_p2;
  logic                   write_p2;

  assign accept  = (state_q == S_IDLE) && start;
  assign vld_p0  = (state_q == S_RUN);
  assign last_p0 = (col_p0 == CW'(SPR_W - 1)) && (row_p0 == RW'(SPR_H - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)   state_d = S_RUN;
      S_RUN:   if (last_p0) state_d = S_FLUSH;
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stage 0: address generation. The counters return to 0 after the final
  // address so rom_addr rests at 0 while idle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      col_p0  <= '0;
      row_p0  <= '0;
      addr_p0 <= '0;
    end else if (accept) begin
      col_p0  <= '0;
      row_p0  <= '0;
      addr_p0 <= '0;
    end else if (vld_p0) begin
      if (last_p0) begin
        col_p0  <= '0;
        row_p0  <= '0;
        addr_p0 <= '0;
      end else begin
        addr_p0 <= addr_p0 + AW'(1);
        if (col_p0 == CW'(SPR_W - 1)) begin
          col_p0 <= '0;
          row_p0 <= row_p0 + RW'(1);
        end else begin
          col_p0 <= col_p0 + CW'(1);
        end
      end
    end
  end

  // The state is already IDLE in the cycle before done, so a start arriving
  // there is accepted; busy is held separately so it stays high until the
  // last pixel has left stage 2 (or a chained draw keeps it high).
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fin_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      fin_q  <= (state_q == S_FLUSH);
      done_q <= fin_q;
      if (accept)     busy_q <= 1'b1;
      else if (fin_q) busy_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      x0_q    <= x0;
      y0_q    <= y0;
      erase_q <= erase;
      bg_q    <= bg_color;
    end
  end

  // Stage 1: align (col,row,valid) with rom_data from the registered ROM.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) vld_p1 <= 1'b0;
    else         vld_p1 <= vld_p0;
  end

  always_ff @(posedge clock) begin
    col_p1 <= col_p0;
    row_p1 <= row_p0;
  end

  assign sum_x_p1  = add_x(x0_q, col_p1);
  assign sum_y_p1  = add_y(y0_q, row_p1);
  assign opaque_p1 = (rom_data != COLOR_DEPTH'(TRANSPARENT));

  // Stage 2: registered pixel outputs to the adapter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_p2     <= '0;
      y_p2     <= '0;
      color_p2 <= '0;
      write_p2 <= 1'b0;
    end else begin
      x_p2     <= sum_x_p1[nX-1:0];
      y_p2     <= sum_y_p1[nY-1:0];
      color_p2 <= erase_q ? bg_q : rom_data;
      write_p2 <= vld_p1 && opaque_p1 && on_screen(sum_x_p1, sum_y_p1);
    end
  end

  assign rom_addr = addr_p0;
  assign x        = x_p2;
  assign y        = y_p2;
  assign color    = color_p2;
  assign write    = write_p2;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sprite_drawer.sv
module tb_sprite_drawer;

  localparam int N = 256;

  logic       clock;
  logic       resetn;
  logic       start;
  logic       erase;
  logic [9:0] x0;
  logic [8:0] y0;
  logic [8:0] bg_color;
  logic [7:0] rom_addr;
  logic [8:0] rom_data;
  logic [9:0] x;
  logic [8:0] y;
  logic [8:0] color;
  logic       write;
  logic       busy;
  logic       done;

  logic [8:0] rom_mem [256];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int x0;
    int y0;
    bit er;
    int bg;
    int mode;
    int exp_wr;
    int fx;
    int fy;
    int lx;
    int ly;
  } vec_t;

  vec_t vecs [6];

  sprite_drawer dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .erase    (erase),
    .x0       (x0),
    .y0       (y0),
    .bg_color (bg_color),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .x        (x),
    .y        (y),
    .color    (color),
    .write    (write),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous ROM: data appears one cycle after the address.
  always @(posedge clock) rom_data <= rom_mem[rom_addr];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic fill_rom(input int mode);
    for (int i = 0; i < 256; i++) begin
      if (mode == 0)          rom_mem[i] = 9'h1FF;
      else if ((i % 2) == 1)  rom_mem[i] = 9'h0A5;
      else                    rom_mem[i] = 9'h000;
    end
  endtask

  // Runs one draw and checks every cycle of it against a reference model.
  // skip_start: start was already sampled by the previous draw's last edge.
  // poke:       pulse start with other coordinates mid-draw.
  // chain:      raise start for nxt so it is sampled at E(N+2).
  task automatic run_draw(input vec_t v, input bit skip_start, input bit poke,
                          input bit chain, input vec_t nxt);
    int wr_cnt, fx, fy, lx, ly, last_c, n, col, row, ex, ey, d, ec, prints;
    bit ew, ctl_err, pix_bad;
    wr_cnt = 0; fx = -1; fy = -1; lx = -1; ly = -1; prints = 0; ctl_err = 0;
    if (!skip_start) begin
      @(negedge clock);
      x0 = 10'(v.x0); y0 = 9'(v.y0); erase = v.er; bg_color = 9'(v.bg);
      start = 1'b1;
      @(posedge clock); #1;
    end
    start = 1'b0;
    check("busy_after_e0", int'(busy), 1);
    check("rom_addr_after_e0", int'(rom_addr), 0);
    last_c = chain ? N + 2 : N + 3;
    for (int c = 1; c <= last_c; c++) begin
      @(posedge clock); #1;
      if (c >= 1 && c <= N - 1 && rom_addr !== 8'(c)) ctl_err = 1;
      if (c >= 2 && c <= N + 1) begin
        n   = c - 2;
        col = n % 16;
        row = n / 16;
        d   = int'(rom_mem[n]);
        ex  = v.x0 + col;
        ey  = v.y0 + row;
        ew  = (d != 0) && (ex < 640) && (ey < 480);
        ec  = v.er ? v.bg : d;
        pix_bad = (write !== ew) ||
                  (ew && (x !== 10'(ex) || y !== 9'(ey) || color !== 9'(ec)));
        checks++;
        if (pix_bad) begin
          failures++;
          if (prints < 8)
            $display("FAIL pix%0d write=%0b x=%0d y=%0d color=%0h required write=%0b x=%0d y=%0d color=%0h",
                     n, write, x, y, color, ew, ex, ey, ec);
          prints++;
        end
      end else if (write) begin
        ctl_err = 1;
      end
      if (write) begin
        wr_cnt++;
        if (fx < 0) begin fx = int'(x); fy = int'(y); end
        lx = int'(x); ly = int'(y);
      end
      if (c <= N + 1) begin
        if (busy !== 1'b1 || done !== 1'b0) ctl_err = 1;
      end else if (c == N + 2) begin
        check("done_pulse", int'(done), 1);
        check("busy_at_done", int'(busy), chain ? 1 : 0);
        check("write_at_done", int'(write), 0);
      end else begin
        check("done_clears", int'(done), 0);
      end
      if (poke && c == 10) begin
        x0 = 10'(v.x0 + 37); y0 = 9'(v.y0 + 11); start = 1'b1;
      end
      if (poke && c == 11) start = 1'b0;
      if (chain && c == N + 1) begin
        x0 = 10'(nxt.x0); y0 = 9'(nxt.y0); erase = nxt.er;
        bg_color = 9'(nxt.bg); start = 1'b1;
      end
    end
    check("ctrl_timing_ok", int'(ctl_err), 0);
    check("write_count", wr_cnt, v.exp_wr);
    check("first_x", fx, v.fx);
    check("first_y", fy, v.fy);
    check("last_x", lx, v.lx);
    check("last_y", ly, v.ly);
  endtask

  initial begin
    int wr_seen;
    vec_t dummy;
    vecs[0] = '{x0:100, y0:50,  er:0, bg:0,     mode:0, exp_wr:256, fx:100, fy:50,  lx:115, ly:65};
    vecs[1] = '{x0:0,   y0:0,   er:0, bg:0,     mode:1, exp_wr:128, fx:1,   fy:0,   lx:15,  ly:15};
    vecs[2] = '{x0:632, y0:472, er:0, bg:0,     mode:0, exp_wr:64,  fx:632, fy:472, lx:639, ly:479};
    vecs[3] = '{x0:200, y0:100, er:1, bg:0,     mode:1, exp_wr:128, fx:201, fy:100, lx:215, ly:115};
    vecs[4] = '{x0:630, y0:470, er:1, bg:'h155, mode:1, exp_wr:50,  fx:631, fy:470, lx:639, ly:479};
    vecs[5] = '{x0:0,   y0:470, er:0, bg:0,     mode:0, exp_wr:160, fx:0,   fy:470, lx:15,  ly:479};
    dummy   = vecs[0];

    resetn = 1'b0; start = 1'b0; erase = 1'b0;
    x0 = '0; y0 = '0; bg_color = '0;
    fill_rom(0);
    #1;
    check("rst_write", int'(write), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    repeat (3) @(posedge clock);
    @(negedge clock); resetn = 1'b1;
    repeat (2) @(posedge clock);

    for (int i = 0; i < 6; i++) begin
      fill_rom(vecs[i].mode);
      run_draw(vecs[i], 1'b0, 1'b0, 1'b0, dummy);
      repeat (2) @(posedge clock);
    end

    // start while busy is ignored; coordinates of the running draw hold.
    fill_rom(0);
    run_draw(vecs[0], 1'b0, 1'b1, 1'b0, dummy);
    repeat (2) @(posedge clock);

    // Back-to-back: second start sampled at E(N+2), no pixels lost.
    fill_rom(1);
    run_draw(vecs[1], 1'b0, 1'b0, 1'b1, vecs[3]);
    run_draw(vecs[3], 1'b1, 1'b0, 1'b0, dummy);
    repeat (2) @(posedge clock);

    // Reset in the middle of a draw.
    fill_rom(0);
    @(negedge clock);
    x0 = 10'd100; y0 = 9'd50; erase = 1'b0; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (20) @(posedge clock);
    #3 resetn = 1'b0;
    #1;
    check("mid_rst_write", int'(write), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_rom_addr", int'(rom_addr), 0);
    check("mid_rst_x", int'(x), 0);
    check("mid_rst_y", int'(y), 0);
    check("mid_rst_color", int'(color), 0);
    @(negedge clock); resetn = 1'b1;
    wr_seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clock); #1;
      if (write || busy || done) wr_seen++;
    end
    check("no_activity_after_reset", wr_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_drawer.md
# sprite_drawer

Pixel-writer stage that sits directly upstream of `vga_adapter` and drives its `x`, `y`, `color` and `write` inputs. On a `start` pulse it rasterises one fixed-size sprite from an external synchronous ROM at a given screen position, one pixel per clock. It skips transparent pixels and clips anything off-screen. In erase mode it overwrites the sprite's opaque footprint with a background colour, which is how game objects are moved without redrawing the whole frame.

## Interface
- `nX`, 10, X coordinate width (640x480 mode).
- `nY`, 9, Y coordinate width.
- `COLOR_DEPTH`, 9, pixel colour width (3 bits per channel).
- `SPR_W`, 16, sprite width in pixels.
- `SPR_H`, 16, sprite height in pixels.
- `AW`, 8, ROM address width; 2^AW >= SPR_W*SPR_H.
- `X_MAX`, 640, screen width.
- `Y_MAX`, 480, screen height.
- `TRANSPARENT`, 0, ROM colour value treated as transparent.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  system clock (CLOCK_50 domain).
- `resetn`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a draw; sampled only in IDLE.
- `erase`  in  1  latched with `start`; 1 = paint `bg_color` over opaque pixels.
- `x0`  in  nX  sprite top-left X; latched with `start`.
- `y0`  in  nY  sprite top-left Y; latched with `start`.
- `bg_color`  in  COLOR_DEPTH  erase colour; latched with `start`.
- `rom_addr`  out  AW  sprite ROM address, row-major (`row*SPR_W+col`).
- `rom_data`  in  COLOR_DEPTH  ROM data; valid one cycle after `rom_addr`, because the ROM registers its address.
- `x`  out  nX  pixel X to the adapter.
- `y`  out  nY  pixel Y to the adapter.
- `color`  out  COLOR_DEPTH  pixel colour to the adapter.
- `write`  out  1  pixel write strobe to the adapter.
- `busy`  out  1  draw in progress.
- `done`  out  1  one-cycle pulse when a draw completes.

## Operation
- **States:** IDLE, RUN, FLUSH.
- **IDLE to RUN:** occurs when `start=1` at a clock edge. `x0`, `y0`, `erase` and `bg_color` are latched at that edge; `col` and `row` are cleared to 0.
- **RUN:** `rom_addr` presents the current (`row`,`col`) each cycle. `col` increments, wrapping to 0 at SPR_W-1 with `row`+1. After the address for (SPR_H-1, SPR_W-1) is issued, the block enters FLUSH.
- **FLUSH:** drains the 2-stage pipeline. It then pulses `done`, drops `busy` and returns to IDLE.
- **Pipeline stage 1:** delays (`col`,`row`,valid) by one cycle to align with `rom_data`.
- **Pipeline stage 2:** registers the outputs:
  - `x = x0+col` and `y = y0+row`, truncated to nX/nY.
  - `color = erase ? bg_color : rom_data`.
  - `write = valid & opaque & onscreen`.
- **opaque:** `rom_data != TRANSPARENT`. This applies in both modes; erase paints only the sprite footprint.
- **onscreen:** `x0+col < X_MAX` and `y0+row < Y_MAX`. The sums are computed at nX+1 / nY+1 bits so wrap-around cannot alias onto the left or top edge.
- **Output order:** pixels are emitted in raster order; clipped and transparent pixels produce `write=0` but still consume their cycle.
- **`start` while busy:** ignored, not queued.
- **Reset (any time, including mid-draw):**
  - The state returns to IDLE immediately.
  - `rom_addr`, `x`, `y`, `color`, `write`, `busy` and `done` all go to 0.
  - No partial pixel is written after reset asserts.

## Timing
Let N = SPR_W*SPR_H and E0 be the edge that samples `start`.

| After edge | Behaviour |
|---|---|
| E0 | `busy=1`, `rom_addr=0` |
| Ek, 1 ≤ k ≤ N-1 | `rom_addr=k` |
| E(n+2), 0 ≤ n ≤ N-1 | pixel n is on `x`/`y`/`color`/`write` for exactly one cycle |
| E(N+2) | `done=1`, `busy=0`, `write=0`; `done` clears after E(N+3) |

- Throughput is 1 pixel per clock; the draw takes N+2 cycles with `busy` high.
- The earliest next `start` is sampled at E(N+2), in the same cycle `done` is high. It is accepted because the state is already IDLE.
- `write` is a registered output with no combinational path from any input.

## Test plan
1. **Reset:** assert `resetn=0` mid-draw.
   - All outputs must be 0 asynchronously.
   - After release, no `write` may occur until a new `start`.
2. **Opaque draw:** ROM filled with 0x1FF, `start` with (`x0`=100, `y0`=50, `erase`=0).
   - Exactly 256 writes in raster order.
   - The first write is at (100,50) two cycles after E0; the last is at (115,65).
   - `done` pulses once 258 cycles after E0.
3. **Transparency:** ROM holds 0 at even columns and 0x0A5 at odd columns; draw at (0,0).
   - Exactly 128 writes, all at odd x, all `color`=0x0A5.
4. **Clipping:** draw at (632,472).
   - Exactly 64 writes, all with x in 632..639 and y in 472..479.
   - No write may land at x<16 or y<16 (no wrap).
5. **Erase:** same ROM as test 3, `erase`=1, `bg_color`=0x000, draw at (200,100).
   - 128 writes with `color`=0 at the same positions as a normal draw.
6. **Busy start and back-to-back:**
   - Pulse `start` with different (`x0`,`y0`) at cycle 10 of a draw: it is ignored and the current draw's coordinates are unchanged.
   - Pulse `start` in the `done` cycle: the second draw begins with no gap and no lost pixels.
